isqrt_hs: RTL and testbench

// - Iterative integer square root with valid/ready handshakes on input and output.
// - Returns floor root and remainder. STEPS_PER_CYCLE trades area for latency.
// - Handles signed negative inputs by flagging them; no stall on bad data.
// - Sits in the watchdog datapath wherever a magnitude is derived from a sum of squares.

---
 rtl/isqrt_pkg.sv | 19 +
 rtl/isqrt_step.sv | 27 ++
 rtl/isqrt_hs.sv | 124 ++++++++++++
 tb/tb_isqrt_hs.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/isqrt_pkg.sv
// Shared types and sizing helpers for the iterative integer square root.
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of clocks spent in RUN for a given root width and digits per clock.
  function automatic int digit_steps(input int out_w, input int spc);
    return out_w / spc;
  endfunction

  function automatic int cnt_width(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root digit: brings in two radicand bits and resolves one root bit.
module isqrt_step #(
  parameter  int OUT_WIDTH = 16,
  localparam int RW        = OUT_WIDTH + 2
) (
  input  logic [RW-1:0]        rem,
  input  logic [OUT_WIDTH-1:0] root,
  input  logic [1:0]           bits,
  output logic [RW-1:0]        rem_nxt,
  output logic [OUT_WIDTH-1:0] root_nxt
);

  logic [RW-1:0] rem_sh;
  logic [RW-1:0] trial;
  logic          fits;
  logic          unused_rem_top;

  // Partial remainder never exceeds twice the partial root, so its top two bits
  // are always zero before the shift and can be dropped.
  assign rem_sh         = {rem[RW-3:0], bits};
  assign trial          = {root, 2'b01};
  assign fits           = (rem_sh >= trial);
  assign rem_nxt        = fits ? (rem_sh - trial) : rem_sh;
  assign root_nxt       = {root[OUT_WIDTH-2:0], fits};
  assign unused_rem_top = ^rem[RW-1:RW-2];

endmodule

// File: rtl/isqrt_hs.sv
// Iterative integer square root with valid/ready handshakes on both sides.
// Define ISQRT_ROUND_EN to round root_out to nearest (saturating); default is floor.
module isqrt_hs
  import isqrt_pkg::*;
#(
  parameter  int IN_WIDTH        = 32,
  parameter  int STEPS_PER_CYCLE = 1,
  parameter  int SIGNED_IN       = 1,
  localparam int OUT_WIDTH       = IN_WIDTH / 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  x_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] root_out,
  output logic [OUT_WIDTH:0]   rem_out,
  output logic                 is_neg,
  output logic                 busy
);

  localparam int RW    = OUT_WIDTH + 2;
  localparam int NSTEP = digit_steps(OUT_WIDTH, STEPS_PER_CYCLE);
  localparam int CW    = cnt_width(NSTEP);

  state_t               state, state_nxt;
  logic [IN_WIDTH-1:0]  shreg;
  logic [RW-1:0]        rem_q;
  logic [OUT_WIDTH-1:0] root_q;
  logic [CW-1:0]        cnt;
  logic                 accept, x_neg, last_step;
  logic [OUT_WIDTH-1:0] root_fin;

  logic [RW-1:0]        rem_c  [STEPS_PER_CYCLE+1];
  logic [OUT_WIDTH-1:0] root_c [STEPS_PER_CYCLE+1];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign x_neg     = (SIGNED_IN != 0) && x_in[IN_WIDTH-1];
  assign last_step = (cnt == CW'(1));

  assign rem_c[0]  = rem_q;
  assign root_c[0] = root_q;

  // Each stage consumes the next two radicand bits from the top of the shift register.
  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    isqrt_step #(.OUT_WIDTH(OUT_WIDTH)) u_step (
      .rem      (rem_c[i]),
      .root     (root_c[i]),
      .bits     (shreg[IN_WIDTH-1-2*i -: 2]),
      .rem_nxt  (rem_c[i+1]),
      .root_nxt (root_c[i+1])
    );
  end

`ifdef ISQRT_ROUND_EN
  // Round up when x exceeds r^2 + r; an all-ones root stays put instead of wrapping.
  always_comb begin
    root_fin = root_c[STEPS_PER_CYCLE];
    if ((rem_c[STEPS_PER_CYCLE] > RW'(root_c[STEPS_PER_CYCLE])) && !(&root_c[STEPS_PER_CYCLE]))
      root_fin = root_c[STEPS_PER_CYCLE] + 1'b1;
  end
`else
  logic unused_rem_msb;
  assign root_fin       = root_c[STEPS_PER_CYCLE];
  assign unused_rem_msb = rem_c[STEPS_PER_CYCLE][RW-1];
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next state defaults to the current state first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = x_neg ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt      <= '0;
      root_out <= '0;
      rem_out  <= '0;
      is_neg   <= 1'b0;
    end else if (accept) begin
      shreg  <= x_in;
      rem_q  <= '0;
      root_q <= '0;
      cnt    <= CW'(NSTEP);
      if (x_neg) begin
        root_out <= '0;
        rem_out  <= '0;
        is_neg   <= 1'b1;
      end
    end else if (state == RUN) begin
      shreg  <= shreg << (2 * STEPS_PER_CYCLE);
      rem_q  <= rem_c[STEPS_PER_CYCLE];
      root_q <= root_c[STEPS_PER_CYCLE];
      cnt    <= cnt - CW'(1);
      if (last_step) begin
        root_out <= root_fin;
        rem_out  <= rem_c[STEPS_PER_CYCLE][OUT_WIDTH:0];
        is_neg   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_isqrt_hs.sv
// Bench for isqrt_hs: three instances (1, 2, 4 digits per clock; signed and unsigned) share stimulus.
module tb_isqrt_hs;

  localparam int ND = 3;
  localparam int SPC [ND] = '{1, 2, 4};
  localparam bit SGN [ND] = '{1'b1, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x_in = '0;

  logic        ir [ND];
  logic        ov [ND];
  logic        ng [ND];
  logic        bz [ND];
  logic [15:0] root_o [ND];
  logic [16:0] rem_o [ND];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  isqrt_hs #(.IN_WIDTH(32), .STEPS_PER_CYCLE(1), .SIGNED_IN(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .x_in(x_in),
    .out_valid(ov[0]), .out_ready(out_ready), .root_out(root_o[0]), .rem_out(rem_o[0]),
    .is_neg(ng[0]), .busy(bz[0]));

  isqrt_hs #(.IN_WIDTH(32), .STEPS_PER_CYCLE(2), .SIGNED_IN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .x_in(x_in),
    .out_valid(ov[1]), .out_ready(out_ready), .root_out(root_o[1]), .rem_out(rem_o[1]),
    .is_neg(ng[1]), .busy(bz[1]));

  isqrt_hs #(.IN_WIDTH(32), .STEPS_PER_CYCLE(4), .SIGNED_IN(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .x_in(x_in),
    .out_valid(ov[2]), .out_ready(out_ready), .root_out(root_o[2]), .rem_out(rem_o[2]),
    .is_neg(ng[2]), .busy(bz[2]));

  // Reference: real-valued sqrt corrected to the exact integer floor, then optional rounding.
  function automatic void model(input logic [31:0] x, input bit sgn,
                                output logic [15:0] r, output logic [16:0] rm,
                                output logic n);
    longint xv, s;
    xv = longint'(x);
    if (sgn && x[31]) begin
      r = '0; rm = '0; n = 1'b1;
      return;
    end
    s = longint'($sqrt(real'(xv)));
    while (s * s > xv) s--;
    while ((s + 1) * (s + 1) <= xv) s++;
    rm = 17'(xv - s * s);
`ifdef ISQRT_ROUND_EN
    if (4 * xv > (2 * s + 1) * (2 * s + 1)) s++;
    if (s > 65535) s = 65535;
`endif
    r = 16'(s);
    n = 1'b0;
  endfunction

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if ({ov[d], ng[d], bz[d], ir[d], root_o[d], rem_o[d]} !== {3'b000, 1'b1, 16'h0, 17'h0})
        $display("FAIL %s dut%0d: got ov=%b neg=%b busy=%b rdy=%b root=%0d rem=%0d, want ov=0 neg=0 busy=0 rdy=1 root=0 rem=0",
                 tag, d, ov[d], ng[d], bz[d], ir[d], root_o[d], rem_o[d]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    #12;
    check_reset_values("reset_asserted");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("reset_release");
  endtask

  // One transaction through all instances, optionally holding out_ready low for `hold` cycles.
  task automatic do_txn(input logic [31:0] x, input int hold);
    logic [15:0] er [ND];
    logic [16:0] em [ND];
    logic        en [ND];
    int          lat [ND];
    int          cyc;
    bit          all_done;
    for (int d = 0; d < ND; d++) begin
      model(x, SGN[d], er[d], em[d], en[d]);
      lat[d] = 0;
    end
    @(negedge clk);
    x_in = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    forever begin
      all_done = 1'b1;
      for (int d = 0; d < ND; d++) begin
        if (lat[d] == 0 && ov[d] === 1'b1) lat[d] = cyc;
        if (lat[d] == 0) all_done = 1'b0;
      end
      if (all_done || cyc >= 40) break;
      @(posedge clk); #1;
      cyc++;
    end
    for (int d = 0; d < ND; d++) begin
      int exp_lat;
      exp_lat = en[d] ? 1 : (16 / SPC[d] + 1);
      n_checks++;
      if (lat[d] != exp_lat)
        $display("FAIL latency dut%0d x=%h: got %0d cycles (0 = timeout), want %0d", d, x, lat[d], exp_lat);
      else n_pass++;
      n_checks++;
      if ({root_o[d], rem_o[d], ng[d]} !== {er[d], em[d], en[d]})
        $display("FAIL result dut%0d x=%h: got root=%0d rem=%0d neg=%b, want root=%0d rem=%0d neg=%b",
                 d, x, root_o[d], rem_o[d], ng[d], er[d], em[d], en[d]);
      else n_pass++;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x_in = ~x;
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if ({ov[d], ir[d], root_o[d], rem_o[d], ng[d]} !== {2'b10, er[d], em[d], en[d]})
          $display("FAIL hold dut%0d cyc%0d: got ov=%b rdy=%b root=%0d rem=%0d, want ov=1 rdy=0 root=%0d rem=%0d",
                   d, h, ov[d], ir[d], root_o[d], rem_o[d], er[d], em[d]);
        else n_pass++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if ({ov[d], ir[d], bz[d], root_o[d], rem_o[d]} !== {3'b010, er[d], em[d]})
        $display("FAIL handshake dut%0d: got ov=%b rdy=%b busy=%b root=%0d rem=%0d, want ov=0 rdy=1 busy=0 root=%0d rem=%0d",
                 d, ov[d], ir[d], bz[d], root_o[d], rem_o[d], er[d], em[d]);
      else n_pass++;
    end
    @(negedge clk) out_ready = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] vec [7] = '{32'd0, 32'd1, 32'd16, 32'd24, 32'd17, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    foreach (vec[i]) do_txn(vec[i], 0);
  endtask

  task automatic test_backpressure();
    do_txn(32'd1_000_000, 10);
    do_txn(32'd99, 0);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    x_in = 32'h1234_5678;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid_run");
    @(negedge clk) rst_n = 1'b1;
    do_txn(32'h0000_0051, 0);
  endtask

  task automatic test_random();
    logic [31:0] x;
    for (int i = 0; i < 60; i++) begin
      case (i % 4)
        0: x = $urandom;
        1: x = $urandom_range(0, 1000);
        2: begin x = $urandom_range(0, 65535); x = x * x + $urandom_range(0, 2); end
        default: x = $urandom & 32'h7FFF_FFFF;
      endcase
      do_txn(x, (i % 7 == 0) ? 2 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
